// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared operation and FSM state types for the divider
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIVIDE = 2'b01,
    ST_DONE   = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring divide iteration (combinational)
module div_step #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  dividend_bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_bit_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  // rem_i < divisor_i always, so one extra bit is enough to see the borrow
  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~diff[DATA_WIDTH];
  assign rem_o   = q_bit_o ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed/unsigned divider, one quotient bit per cycle
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OP_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_start,
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_div_by_zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state_q, state_d;
  div_op_e               op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  dbz_q, dbz_d;

  div_op_e               op_in;
  logic                  in_signed, in_rem;
  logic                  dvd_neg, dvs_neg;
  logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;
  logic                  div_zero, sgn_overflow;

  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_qbit;
  logic [DATA_WIDTH-1:0] quo_next;
  logic [DATA_WIDTH-1:0] fin_quo, fin_rem;
  logic                  op_is_rem;

  assign op_in        = div_op_e'(i_op[1:0]);
  assign in_signed    = (op_in == OP_DIV) || (op_in == OP_REM);
  assign in_rem       = (op_in == OP_REM) || (op_in == OP_REMU);
  assign dvd_neg      = in_signed & i_dividend[DATA_WIDTH-1];
  assign dvs_neg      = in_signed & i_divisor[DATA_WIDTH-1];
  assign dvd_mag      = dvd_neg ? -i_dividend : i_dividend;
  assign dvs_mag      = dvs_neg ? -i_divisor : i_divisor;
  assign div_zero     = (i_divisor == '0);
  assign sgn_overflow = in_signed && (i_dividend == MOST_NEG) && (&i_divisor);

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_i         (rem_q),
    .dividend_bit_i(quo_q[DATA_WIDTH-1]),
    .divisor_i     (dvs_q),
    .rem_o         (step_rem),
    .q_bit_o       (step_qbit)
  );

  // Dividend bits shift out of quo_q as quotient bits shift in
  assign quo_next  = {quo_q[DATA_WIDTH-2:0], step_qbit};
  assign fin_quo   = q_neg_q ? -quo_next : quo_next;
  assign fin_rem   = r_neg_q ? -step_rem : step_rem;
  assign op_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d    = op_in;
          cnt_d   = '0;
          quo_d   = dvd_mag;
          rem_d   = '0;
          dvs_d   = dvs_mag;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          dbz_d   = 1'b0;
          if (div_zero) begin
            state_d  = ST_DONE;
            result_d = in_rem ? i_dividend : '1;
            dbz_d    = 1'b1;
          end else if (sgn_overflow) begin
            state_d  = ST_DONE;
            result_d = in_rem ? '0 : i_dividend;
          end else begin
            state_d = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        quo_d = quo_next;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_DONE;
          result_d = op_is_rem ? fin_rem : fin_quo;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_DIV;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dbz_q    <= dbz_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_result      = result_q;
  assign o_div_by_zero = o_done & dbz_q;

endmodule
